apb_slave: RTL
==============

Name: apb_slave

Overview:
- APB completer (slave) for the 8-bit APB bus driven by the team's APB master.
- Decodes a local register file of DEPTH x 8-bit registers.
- Inserts a fixed, parameterised number of wait states before each completion.
- Returns read data and flags out-of-range accesses with pslverr; sits at the far end of the bus from the master.

Parameters:
- DEPTH, 16: number of 8-bit registers, at addresses 0..DEPTH-1 (1..256).
- WAIT_CYCLES, 2: access-phase cycles with pready low before completion (0..15).

Ports:
- pclk  input  1  bus clock; all state updates on the rising edge.
- preset  input  1  asynchronous, active-low reset.
- psel  input  1  slave select from the master.
- pena  input  1  enable; high marks the access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  8  byte address.
- pwr_data  input  8  write data.
- pready  output  1  transfer completes in this cycle.
- prdata  output  8  read data; valid only while pready=1 and pwrite=0.
- pslverr  output  1  error response; valid only while pready=1.

Behaviour:
- Reset (preset=0, asynchronous):
  - state=IDLE, wait counter=0, latched addr/write/data=0.
  - All DEPTH registers=0; pready=0, prdata=0, pslverr=0.
- Reset mid-transfer: any in-progress transfer is dropped, no register is written, and outputs drop to 0 immediately.
- Two-state FSM, IDLE and ACCESS.
- IDLE:
  - If psel=1 and pena=0 (setup phase): latch paddr, pwrite and pwr_data; load counter=WAIT_CYCLES; go to ACCESS.
  - psel=1 with pena=1 while in IDLE is a protocol violation: ignored, stay IDLE, pready=0.
- ACCESS:
  - If psel=0, the transfer is aborted: go to IDLE, no write.
  - Else if counter!=0: counter decrements by 1 and pready=0.
  - Else (counter==0, psel=1, pena=1): completion cycle. pready=1.
    - Write to a valid address: the latched data is stored at the following clock edge.
    - Go to IDLE.
- pready, prdata and pslverr are functions of registered state and counter only, with no combinational path from bus inputs.
- Address rule: valid iff latched addr < DEPTH.
  - Invalid address: pslverr=1 in the completion cycle; writes are discarded and prdata=0.
- Read data: prdata = reg[latched addr] in the completion cycle of a valid read; 0 at all other times.
- Latency: completion occurs WAIT_CYCLES+1 cycles after the setup cycle. With WAIT_CYCLES=0, pready=1 in the first access cycle.
- Back-to-back transfers: the master returns to setup directly after completion. The slave is in IDLE in that cycle and accepts it, so there is no idle gap.
- Read-after-write to the same address in consecutive transfers returns the new data.
- Inputs changing during ACCESS: ignored. The values latched in setup are used.

Test Plan:
- Reset check: assert preset=0 mid-ACCESS of a write of 0x5A to addr 3 -> pready=0 immediately; after release, a read of addr 3 returns 0x00.
- Write then read (WAIT_CYCLES=2):
  - Write 0xA5 to addr 0x04 -> pready low for 2 access cycles, high on the 3rd, pslverr=0.
  - Next transfer, read addr 0x04 -> prdata=0xA5 in the pready cycle.
- Out-of-range: write 0x77 to addr 0x10 (DEPTH=16) -> pslverr=1 with pready. A read of 0x10 -> prdata=0x00, pslverr=1. Registers 0..15 are unchanged.
- Back-to-back: write 0x11 to addr 1, then immediately write 0x22 to addr 2 (setup the cycle after pready), then read both -> 0x11 and 0x22; no missed setup.
- Abort and violation:
  - Deassert psel during the wait cycles of a write of 0x33 to addr 5 -> FSM returns to IDLE, addr 5 still 0x00.
  - Drive psel=1, pena=1 from IDLE -> pready stays 0.
- Zero wait (WAIT_CYCLES=0): write 0xFF to addr 15, then read it -> pready=1 in the first access cycle each time; read returns 0xFF.

Source files
------------

// File: rtl/apb_slave.sv
// APB completer with a local DEPTH x 8-bit register file.
// Every access is completed after a fixed number of wait states.
// Out-of-range addresses get an error response, and writes to them are dropped.
module apb_slave #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       psel,
    input  logic       pena,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwr_data,
    output logic       pready,
    output logic [7:0] prdata,
    output logic       pslverr
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [7:0]  addr_q,  addr_d;
    logic [7:0]  data_q,  data_d;
    logic        write_q, write_d;
    logic [7:0]  mem_q [DEPTH];

    logic          wr_en;
    logic          addr_ok;
    logic          done;
    logic [IW-1:0] idx;

    // The bus response depends only on registered state, so there is
    // no combinational path from the bus inputs to the outputs.
    assign addr_ok = ({1'b0, addr_q} < 9'(DEPTH));
    assign idx     = addr_q[IW-1:0];
    assign done    = (state_q == ACCESS) && (cnt_q == '0);
    assign pready  = done;
    assign pslverr = done && !addr_ok;
    assign prdata  = (done && !write_q && addr_ok) ? mem_q[idx] : '0;

    // Next-state logic: latch the request in setup, then count down the wait states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = write_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !pena) begin
                    addr_d  = paddr;
                    data_d  = pwr_data;
                    write_d = pwrite;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (pena) begin
                    wr_en   = write_q && addr_ok;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, wait-counter and request-latch registers.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
        end
    end

    // Register file. A write takes effect at the edge that ends the completion cycle.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= data_q;
        end
    end

endmodule
